// File: rtl/mdu_iter.sv
// Iterative 32-bit multiply/divide unit: radix-2 shift-add multiply and
// restoring shift-subtract divide, one bit per cycle, results in HI/LO.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    // state  | meaning
    // S_IDLE | waiting for start
    // S_RUN  | one multiply/divide iteration per cycle
    // S_FIX  | sign correction and HI/LO write, done pulse
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic             is_signed;
    logic             b_zero_div;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   trial;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            m_q     <= '0;
            p_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            m_q     <= m_d;
            p_q     <= p_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign is_signed  = ~op[0];
    assign b_zero_div = op[1] && (b == '0);
    assign a_mag      = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag      = (is_signed && b[WIDTH-1]) ? -b : b;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = b_zero_div ? S_FIX : S_RUN;
            S_RUN:   if (cnt_q == LAST_ITER) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d   = op_q;
        m_d    = m_q;
        p_d    = p_q;
        q_d    = q_q;
        cnt_d  = cnt_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        dz_d   = dz_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        dbz_d  = dbz_q;
        done_d = 1'b0;

        sum   = {1'b0, p_q} + {1'b0, (q_q[0] ? m_q : {WIDTH{1'b0}})};
        r_sh  = {p_q, q_q[WIDTH-1]};
        trial = r_sh - {1'b0, m_q};
        prod  = {p_q, q_q};
        quo   = neg_q ? -q_q : q_q;
        rem   = rneg_q ? -p_q : p_q;
        if (neg_q) prod = -prod;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op;
                    cnt_d  = '0;
                    p_d    = '0;
                    dz_d   = b_zero_div;
                    neg_d  = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    rneg_d = (op == 2'b10) && a[WIDTH-1];
                    // multiply: Q holds the multiplier; divide: Q holds the dividend
                    m_d    = op[1] ? b_mag : a_mag;
                    q_d    = b_zero_div ? a : (op[1] ? a_mag : b_mag);
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (!op_q[1]) begin
                    p_d = sum[WIDTH:1];
                    q_d = {sum[0], q_q[WIDTH-1:1]};
                end else if (!trial[WIDTH]) begin
                    // remainder stays below the divisor, so it fits in WIDTH bits
                    p_d = trial[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    p_d = r_sh[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
            end
            S_FIX: begin
                done_d = 1'b1;
                dbz_d  = dz_q;
                if (dz_q) begin
                    hi_d = q_q;
                    lo_d = '1;
                end else if (!op_q[1]) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = done_q;
        hi          = hi_q;
        lo          = lo_q;
        div_by_zero = dbz_q;
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed test-plan vectors, random
// operations against an arithmetic reference model, and timing corner cases.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // reference: plain 64-bit arithmetic; SV signed division truncates toward zero
    function automatic void model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                  output logic [31:0] ehi, output logic [31:0] elo, output logic edz);
        longint sa, sb, p, q, r;
        logic [63:0] up;
        edz = 1'b0;
        ehi = '0;
        elo = '0;
        sa  = longint'($signed(ma));
        sb  = longint'($signed(mb));
        case (mop)
            2'd0: begin p = sa * sb; ehi = p[63:32]; elo = p[31:0]; end
            2'd1: begin up = {32'b0, ma} * {32'b0, mb}; ehi = up[63:32]; elo = up[31:0]; end
            default: begin
                if (mb == 32'd0) begin
                    ehi = ma; elo = 32'hFFFF_FFFF; edz = 1'b1;
                end else if (mop == 2'd2) begin
                    q = sa / sb; r = sa % sb;
                    elo = q[31:0]; ehi = r[31:0];
                end else begin
                    elo = ma / mb; ehi = ma % mb;
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'(int'($urandom_range(0, 20)) - 10);
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge where done is seen (or timeout).
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        total += 5;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", hi); end
        if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", lo); end
        if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [8] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd3, 2'd1, 2'd2, 2'd2};
        logic [31:0] t_a  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100,
                                  32'h1234, 32'd2, 32'h8000_0000, 32'd50};
        logic [31:0] t_b  [8] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd7, 32'd0, 32'd3,
                                  32'hFFFF_FFFF, 32'd0};
        logic [31:0] w_hi [8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                                  32'h1234, 32'd0, 32'd0, 32'd50};
        logic [31:0] w_lo [8] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'd14,
                                  32'hFFFF_FFFF, 32'd6, 32'h8000_0000, 32'hFFFF_FFFF};
        logic        w_dz [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 8; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], lat);
            total += 4;
            if (lat !== (w_dz[i] ? 1 : 33)) begin bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, w_dz[i] ? 1 : 33); end
            if (hi !== w_hi[i]) begin bad++; $display("FAIL dir%0d_hi: got %h want %h", i, hi, w_hi[i]); end
            if (lo !== w_lo[i]) begin bad++; $display("FAIL dir%0d_lo: got %h want %h", i, lo, w_lo[i]); end
            if (div_by_zero !== w_dz[i]) begin bad++; $display("FAIL dir%0d_dbz: got %b want %b", i, div_by_zero, w_dz[i]); end
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] x, y, ehi, elo;
        logic        edz;
        int lat;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = pick_val();
            y = pick_val();
            model(o, x, y, ehi, elo, edz);
            run_op(o, x, y, lat);
            total += 5;
            if (lat !== (edz ? 1 : 33)) begin bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, edz ? 1 : 33); end
            if (hi !== ehi) begin bad++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h: got %h want %h", i, o, x, y, hi, ehi); end
            if (lo !== elo) begin bad++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h: got %h want %h", i, o, x, y, lo, elo); end
            if (div_by_zero !== edz) begin bad++; $display("FAIL rnd%0d_dbz: got %b want %b", i, div_by_zero, edz); end
            if (busy !== 1'b0) begin bad++; $display("FAIL rnd%0d_busy_at_done: got %b want 0", i, busy); end
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] x, y, ehi, elo;
        logic        edz;
        int lat, extra;
        x = $urandom; y = $urandom;
        model(2'd0, x, y, ehi, elo, edz);
        start = 1'b1; op = 2'd0; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL ign_busy_after_start: got %b want 1", busy); end
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            start = (lat == 10);
            op = 2'd3; a = $urandom; b = 32'd0;
        end
        start = 1'b0;
        total += 3;
        if (lat !== 33) begin bad++; $display("FAIL ign_latency: got %0d want 33", lat); end
        if (hi !== ehi) begin bad++; $display("FAIL ign_hi: got %h want %h", hi, ehi); end
        if (lo !== elo) begin bad++; $display("FAIL ign_lo: got %h want %h", lo, elo); end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        total++;
        if (extra !== 0) begin bad++; $display("FAIL ign_no_second_op: got %0d active cycles want 0", extra); end
    endtask

    task automatic test_reset_mid();
        int seen;
        start = 1'b1; op = 2'd1; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total += 3;
        if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        if (hi !== 32'd0) begin bad++; $display("FAIL rstmid_hi: got %h want 0", hi); end
        if (lo !== 32'd0) begin bad++; $display("FAIL rstmid_lo: got %h want 0", lo); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL rstmid_no_done: got %0d pulses want 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ehi, elo;
        logic        edz;
        int lat;
        run_op(2'd1, 32'd1000, 32'd1000, lat);
        total += 3;
        if (lat !== 33) begin bad++; $display("FAIL b2b_first_latency: got %0d want 33", lat); end
        if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_in_done: got %b want 0", busy); end
        if (lo !== 32'd1_000_000) begin bad++; $display("FAIL b2b_first_lo: got %h want %h", lo, 32'd1_000_000); end
        model(2'd2, 32'hFFFF_FF00, 32'd9, ehi, elo, edz);
        run_op(2'd2, 32'hFFFF_FF00, 32'd9, lat);
        total += 3;
        if (lat !== 33) begin bad++; $display("FAIL b2b_second_latency: got %0d want 33", lat); end
        if (hi !== ehi) begin bad++; $display("FAIL b2b_second_hi: got %h want %h", hi, ehi); end
        if (lo !== elo) begin bad++; $display("FAIL b2b_second_lo: got %h want %h", lo, elo); end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_one_cycle: got %b want 0", done); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
